// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the reset-time jump-vector generator.
//   boot_state_t : jam sequence states (opcode, low address, high address, done)
//   JP_OPCODE    : Z80 unconditional jump opcode forced onto the data bus
//   VECT_SEL0..3 : selectable boot targets used when BOOT_VECT_SW_EN is defined
//   boot_vect()  : maps the two sense-switch bits to a jump target
package boot_pkg;

  typedef enum logic [1:0] {
    OPC  = 2'd0,
    LADR = 2'd1,
    HADR = 2'd2,
    DONE = 2'd3
  } boot_state_t;

  localparam logic [7:0]  JP_OPCODE = 8'hC3;

  localparam logic [15:0] VECT_SEL0 = 16'hF000;
  localparam logic [15:0] VECT_SEL1 = 16'hE000;
  localparam logic [15:0] VECT_SEL2 = 16'hD000;
  localparam logic [15:0] VECT_SEL3 = 16'h0000;

  // Selection 00 uses the instance's own default target, so an override of
  // RST_ADDR on the top still applies when the switches are left at zero.
  function automatic logic [15:0] boot_vect(input logic [1:0]  sel,
                                            input logic [15:0] rst_addr);
    logic [15:0] v;
    v = rst_addr;
    case (sel)
      2'b00:   v = rst_addr;
      2'b01:   v = VECT_SEL1;
      2'b10:   v = VECT_SEL2;
      default: v = VECT_SEL3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: generic two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clocks behind d
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/boot_jump_gen.sv
// boot_jump_gen: after reset, jams "JP rstAdr" into the Z80 by steering the
// CPU data-input mux during the first three memory reads, then goes
// transparent until the next reset or rearm.
//   pll0_250MHz : system clock (rising edge)
//   n_reset     : asynchronous active-low reset
//   z80_mreq_n  : Z80 MREQ, active low, asynchronous
//   z80_rd_n    : Z80 RD, active low, asynchronous
//   rearm       : one-cycle pulse restarting the jam sequence
//   bootSel     : sense-switch target select (only with BOOT_VECT_SW_EN)
//   reset_cs    : high while the jump sequence is still pending
//   c3En_cs     : opcode (0xC3) select
//   ladrEn_cs   : low address byte select
//   hadrEn_cs   : high address byte select
//   rstAdr      : jump target in force
//   bootDone    : jump has been delivered
// Build option: define BOOT_VECT_SW_EN to choose the target from bootSel,
// sampled on every entry to OPC; otherwise rstAdr is fixed at RST_ADDR.
module boot_jump_gen
  import boot_pkg::*;
#(
  parameter logic [15:0] RST_ADDR = VECT_SEL0
) (
  input  logic        pll0_250MHz,
  input  logic        n_reset,
  input  logic        z80_mreq_n,
  input  logic        z80_rd_n,
  input  logic        rearm,
  input  logic [1:0]  bootSel,
  output logic        reset_cs,
  output logic        c3En_cs,
  output logic        ladrEn_cs,
  output logic        hadrEn_cs,
  output logic [15:0] rstAdr,
  output logic        bootDone
);

  logic        mreq_s;
  logic        rd_s;
  logic        mem_rd;
  logic        mem_rd_q;
  logic        rd_end;
  logic        armed;
  logic [1:0]  settle;
  boot_state_t state;
  boot_state_t state_nxt;
  logic        c3_nxt;
  logic        ladr_nxt;
  logic        hadr_nxt;
  logic        sel_rd;

  sync2 #(.RESET_VAL(1'b1)) u_sync_mreq (
    .clk   (pll0_250MHz),
    .rst_n (n_reset),
    .d     (z80_mreq_n),
    .q     (mreq_s)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sync_rd (
    .clk   (pll0_250MHz),
    .rst_n (n_reset),
    .d     (z80_rd_n),
    .q     (rd_s)
  );

  assign mem_rd = !mreq_s && !rd_s;
  assign rd_end = armed && mem_rd_q && !mem_rd;
  assign sel_rd = armed && mem_rd;

  // The synchronisers come out of reset reading "idle" for two clocks even if
  // a read is already under way, so settle blocks arming until they carry
  // real samples. Otherwise a read in progress at reset release would be
  // mistaken for a fresh one.
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      settle   <= 2'b00;
      mem_rd_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      settle   <= {settle[0], 1'b1};
      mem_rd_q <= mem_rd;
      if (rearm)
        armed <= 1'b0;
      else if (settle[1] && !mem_rd)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset)
      state <= OPC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    c3_nxt    = 1'b0;
    ladr_nxt  = 1'b0;
    hadr_nxt  = 1'b0;
    if (rearm) begin
      state_nxt = OPC;
    end else begin
      case (state)
        OPC: begin
          c3_nxt = sel_rd;
          if (rd_end) state_nxt = LADR;
        end
        LADR: begin
          ladr_nxt = sel_rd;
          if (rd_end) state_nxt = HADR;
        end
        HADR: begin
          hadr_nxt = sel_rd;
          if (rd_end) state_nxt = DONE;
        end
        default: state_nxt = DONE;
      endcase
    end
  end

  // Status flags follow the next state so they change on the same edge as
  // the state register.
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      c3En_cs   <= 1'b0;
      ladrEn_cs <= 1'b0;
      hadrEn_cs <= 1'b0;
      reset_cs  <= 1'b1;
      bootDone  <= 1'b0;
    end else begin
      c3En_cs   <= c3_nxt;
      ladrEn_cs <= ladr_nxt;
      hadrEn_cs <= hadr_nxt;
      reset_cs  <= (state_nxt != DONE);
      bootDone  <= (state_nxt == DONE);
    end
  end

`ifdef BOOT_VECT_SW_EN
  // load_pend captures the switches on the first clock after reset release.
  logic load_pend;

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      load_pend <= 1'b1;
      rstAdr    <= RST_ADDR;
    end else begin
      load_pend <= 1'b0;
      if (load_pend || rearm)
        rstAdr <= boot_vect(bootSel, RST_ADDR);
    end
  end
`else
  logic [1:0] unused_boot_sel;

  assign unused_boot_sel = bootSel;
  assign rstAdr          = RST_ADDR;
`endif

endmodule

// File: tb/tb_boot_jump_gen.sv
// tb_boot_jump_gen: scoreboard bench for boot_jump_gen. Each Z80 read pushes
// the select it should produce; the select activity observed over that read
// is popped and compared once the read has finished.
module tb_boot_jump_gen;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        mreq_n;
  logic        rd_n;
  logic        rearm;
  logic [1:0]  bootSel;
  logic        reset_cs;
  logic        c3En;
  logic        ladrEn;
  logic        hadrEn;
  logic [15:0] rstAdr;
  logic        bootDone;

  int          checks   = 0;
  int          failures = 0;
  int          mstate;
  logic [15:0] curAdr;
  logic [2:0]  expQ[$];
  logic [2:0]  winSeen;
  logic [2:0]  prevSel;
  logic [2:0]  monSel;
  int          winRises;
  bit          exclViol;

  always #5 clk = ~clk;

  boot_jump_gen dut (
    .pll0_250MHz (clk),
    .n_reset     (n_reset),
    .z80_mreq_n  (mreq_n),
    .z80_rd_n    (rd_n),
    .rearm       (rearm),
    .bootSel     (bootSel),
    .reset_cs    (reset_cs),
    .c3En_cs     (c3En),
    .ladrEn_cs   (ladrEn),
    .hadrEn_cs   (hadrEn),
    .rstAdr      (rstAdr),
    .bootDone    (bootDone)
  );

  // Accumulates select activity, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    monSel   = {hadrEn, ladrEn, c3En};
    winSeen  = winSeen | monSel;
    winRises = winRises + $countones(monSel & ~prevSel);
    if ($countones(monSel) > 1) exclViol = 1'b1;
    prevSel  = monSel;
  end

  function automatic logic [15:0] tbVect(input logic [1:0] sel);
    logic [15:0] v;
    v = 16'hF000;
`ifdef BOOT_VECT_SW_EN
    case (sel)
      2'b00:   v = 16'hF000;
      2'b01:   v = 16'hE000;
      2'b10:   v = 16'hD000;
      default: v = 16'h0000;
    endcase
`else
    if (sel == 2'b11) v = 16'hF000;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic startWindow();
    winSeen  = 3'b000;
    winRises = 0;
    exclViol = 1'b0;
  endtask

  task automatic scoreWindow(input string tag);
    logic [2:0] got;
    got = expQ.pop_front();
    checkOutput({tag, "Mask"}, {29'd0, winSeen}, {29'd0, got});
    checkOutput({tag, "Pulses"}, winRises, (got != 3'b000) ? 1 : 0);
    checkOutput({tag, "Excl"}, {31'd0, exclViol}, 0);
  endtask

  task automatic pulseRearm();
    @(negedge clk);
    rearm  = 1'b1;
    mstate = 0;
    curAdr = tbVect(bootSel);
    @(negedge clk);
    rearm  = 1'b0;
  endtask

  // One Z80 read of six clocks followed by idle time. isMem=0 gives an I/O
  // read. rearmAtEnd pulses rearm in the cycle where the read end is seen.
  task automatic applyStimulus(input bit isMem, input bit latChk,
                               input bit doneChk, input bit rearmAtEnd);
    logic [2:0] exp;
    exp = 3'b000;
    if (isMem && mstate < 3) begin
      exp = 3'b001 << mstate;
      mstate++;
    end
    expQ.push_back(exp);
    @(negedge clk);
    startWindow();
    mreq_n = !isMem;
    rd_n   = 1'b0;
    repeat (2) @(negedge clk);
    if (latChk) checkOutput("selLatEarly", {29'd0, hadrEn, ladrEn, c3En}, 0);
    @(negedge clk);
    if (latChk) checkOutput("selLatOn", {29'd0, hadrEn, ladrEn, c3En}, {29'd0, exp});
    repeat (3) @(negedge clk);
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    repeat (2) @(negedge clk);
    if (doneChk) checkOutput("doneLatEarly", {31'd0, bootDone}, 0);
    if (rearmAtEnd) begin
      rearm  = 1'b1;
      mstate = 0;
      curAdr = tbVect(bootSel);
    end
    @(negedge clk);
    rearm = 1'b0;
    if (doneChk) checkOutput("doneLatOn", {31'd0, bootDone}, 1);
    if (rearmAtEnd) begin
      checkOutput("rearmWinsDone", {31'd0, bootDone}, 0);
      checkOutput("rearmWinsRstCs", {31'd0, reset_cs}, 1);
    end
    repeat (5) @(negedge clk);
    scoreWindow("sel");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_reset = 1'b0;
    mreq_n  = 1'b1;
    rd_n    = 1'b1;
    rearm   = 1'b0;
    bootSel = 2'b10;
    mstate  = 0;
    prevSel = 3'b000;
    curAdr  = 16'hF000;
    startWindow();
    repeat (2) @(negedge clk);
    checkOutput("rstResetCs", {31'd0, reset_cs}, 1);
    checkOutput("rstSelects", {29'd0, hadrEn, ladrEn, c3En}, 0);
    checkOutput("rstBootDone", {31'd0, bootDone}, 0);
    checkOutput("rstAdrReset", {16'd0, rstAdr}, 32'h0000F000);

    n_reset = 1'b1;
    curAdr  = tbVect(bootSel);
    repeat (4) @(negedge clk);
    checkOutput("rstAdrLoad", {16'd0, rstAdr}, {16'd0, curAdr});

    $display("[TB] basic jam sequence with an I/O read in LADR");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    bootSel = 2'b01;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ioKeepsRstCs", {31'd0, reset_cs}, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("adrHeld", {16'd0, rstAdr}, {16'd0, curAdr});
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("doneRstCs", {31'd0, reset_cs}, 0);
    checkOutput("doneFlag", {31'd0, bootDone}, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] rearm from DONE");
    pulseRearm();
    checkOutput("rearmBootDone", {31'd0, bootDone}, 0);
    checkOutput("rearmRstCs", {31'd0, reset_cs}, 1);
    checkOutput("rearmAdr", {16'd0, rstAdr}, {16'd0, curAdr});
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] rearm coincident with read end in HADR");
    pulseRearm();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("afterRearmDone", {31'd0, bootDone}, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] async reset during HADR select");
    @(negedge clk);
    startWindow();
    mreq_n = 1'b0;
    rd_n   = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("hadrUp", {31'd0, hadrEn}, 1);
    #1;
    n_reset = 1'b0;
    #1;
    checkOutput("asyncHadrDrop", {31'd0, hadrEn}, 0);
    checkOutput("asyncRstCs", {31'd0, reset_cs}, 1);
    checkOutput("asyncBootDone", {31'd0, bootDone}, 0);
    checkOutput("asyncAdr", {16'd0, rstAdr}, 32'h0000F000);
    mstate = 0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    curAdr  = tbVect(bootSel);
    startWindow();
    expQ.push_back(3'b000);
    repeat (5) @(negedge clk);
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    repeat (6) @(negedge clk);
    scoreWindow("heldRead");
    checkOutput("heldReadRstCs", {31'd0, reset_cs}, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("finalAdr", {16'd0, rstAdr}, {16'd0, curAdr});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
